rc5_key_sched: RTL and testbench

- RC5-16/r/16 key-expansion stage that sits directly upstream of the RC5 datapath (algo).
- Expands the 128-bit user key into the round-key table S[0..t-1], where t = 2*(num_rounds+1).
- Holds S in a register file that the datapath reads through a combinational read port.
- Asserts ready once S is valid for the sampled key and round count.

---
 rtl/rc5_pkg.sv | 24 ++
 rtl/rc5_s_table.sv | 39 +++
 rtl/rc5_key_sched.sv | 139 +++++++++++++
 tb/tb_rc5_key_sched.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/rc5_pkg.sv
// Shared RC5-16 definitions for the key schedule and the datapath.
package rc5_pkg;

  localparam int unsigned W       = 16;
  localparam logic [15:0] P16     = 16'hB7E1;
  localparam logic [15:0] Q16     = 16'h9E37;
  localparam int unsigned C_WORDS = 8;
  localparam int unsigned T_MAX   = 64;

  typedef enum logic [1:0] {
    StIdle,
    StInit,
    StMix,
    StDone
  } ks_state_e;

  // Upper half of the doubled word shifted left is the left rotation.
  function automatic logic [15:0] rotl16(input logic [15:0] value, input logic [3:0] amt);
    logic [31:0] dbl;
    dbl = {value, value} << amt;
    return dbl[31:16];
  endfunction

endpackage

// File: rtl/rc5_s_table.sv
// 64x16 S-table: one synchronous write port, two combinational read ports.
// RC5_KS_ZEROIZE_EN adds an asynchronous clear of every entry on rst.
module rc5_s_table
  import rc5_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [5:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [5:0]  mix_raddr,
  output logic [15:0] mix_rdata,
  input  logic [5:0]  ext_raddr,
  output logic [15:0] ext_rdata
);

  logic [15:0] mem [T_MAX];

`ifdef RC5_KS_ZEROIZE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < T_MAX; n++) mem[n] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end
`else
  logic unused_rst;
  assign unused_rst = rst;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
`endif

  assign mix_rdata = mem[mix_raddr];
  assign ext_rdata = mem[ext_raddr];

endmodule

// File: rtl/rc5_key_sched.sv
// RC5-16/r/16 key expansion into the S table read by the datapath.
// RC5_KS_ZEROIZE_EN clears L, A and B when the mix finishes.
module rc5_key_sched
  import rc5_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [4:0]   num_rounds,
  output logic         busy,
  output logic         ready,
  input  logic [5:0]   s_raddr,
  output logic [15:0]  s_rdata
);

  ks_state_e   state_q, state_d;
  logic [6:0]  t_q, t_d;
  logic [6:0]  i_q, i_d;
  logic [2:0]  j_q, j_d;
  logic [7:0]  k_q, k_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [15:0] l_q [C_WORDS];
  logic [15:0] l_d [C_WORDS];

  logic        s_we;
  logic [15:0] s_wdata;
  logic [15:0] s_mix;
  logic [15:0] a_sum, a_new, ab_sum, b_sum, b_new, init_word;
  logic [7:0]  t_eff, mix_len;
  logic [6:0]  i_inc;

  rc5_s_table u_s_table (
    .clk       (clk),
    .rst       (rst),
    .we        (s_we),
    .waddr     (i_q[5:0]),
    .wdata     (s_wdata),
    .mix_raddr (i_q[5:0]),
    .mix_rdata (s_mix),
    .ext_raddr (s_raddr),
    .ext_rdata (s_rdata)
  );

  always_comb begin
    t_eff     = (t_q < 7'd8) ? 8'd8 : {1'b0, t_q};
    mix_len   = t_eff + (t_eff << 1);
    i_inc     = i_q + 7'd1;
    init_word = P16 + {9'd0, i_q} * Q16;
    a_sum     = s_mix + a_q + b_q;
    a_new     = rotl16(a_sum, 4'd3);
    ab_sum    = a_new + b_q;
    b_sum     = l_q[j_q] + ab_sum;
    b_new     = rotl16(b_sum, ab_sum[3:0]);
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    l_d     = l_q;
    s_we    = 1'b0;
    s_wdata = '0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StInit;
          t_d     = {1'b0, num_rounds, 1'b0} + 7'd2;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          a_d     = '0;
          b_d     = '0;
          for (int m = 0; m < C_WORDS; m++) l_d[m] = key[16*m +: 16];
        end
      end
      StInit: begin
        // The slot at i == t is a write-free turnaround cycle before the mix.
        if (i_q == t_q) begin
          state_d = StMix;
          i_d     = '0;
        end else begin
          s_we    = 1'b1;
          s_wdata = init_word;
          i_d     = i_inc;
        end
      end
      StMix: begin
        s_we     = 1'b1;
        s_wdata  = a_new;
        a_d      = a_new;
        b_d      = b_new;
        l_d[j_q] = b_new;
        i_d      = (i_inc == t_q) ? 7'd0 : i_inc;
        j_d      = j_q + 3'd1;
        k_d      = k_q + 8'd1;
        if (k_q == mix_len - 8'd1) begin
          state_d = StDone;
`ifdef RC5_KS_ZEROIZE_EN
          a_d = '0;
          b_d = '0;
          for (int m = 0; m < C_WORDS; m++) l_d[m] = '0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      t_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      for (int m = 0; m < C_WORDS; m++) l_q[m] <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      l_q     <= l_d;
    end
  end

  assign busy  = (state_q == StInit) || (state_q == StMix);
  assign ready = (state_q == StDone);

endmodule

// File: tb/tb_rc5_key_sched.sv
// Randomised self-checking bench for rc5_key_sched against an array-based key-expansion model.
module tb_rc5_key_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic [4:0]   num_rounds;
  logic         busy;
  logic         ready;
  logic [5:0]   s_raddr;
  logic [15:0]  s_rdata;

  int n_vec = 0;
  int n_err = 0;
  int m_s [64];
  int m_l [8];
  int m_a, m_b, m_t;

  rc5_key_sched dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key        (key),
    .num_rounds (num_rounds),
    .busy       (busy),
    .ready      (ready),
    .s_raddr    (s_raddr),
    .s_rdata    (s_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rotl(input int x, input int s);
    return ((x << s) | (x >> (16 - s))) & 'hFFFF;
  endfunction

  function automatic void model(input logic [127:0] k, input int r);
    int i, j, a, b, n;
    m_t = 2 * (r + 1);
    for (int x = 0; x < m_t; x++) m_s[x] = ('hB7E1 + x * 'h9E37) & 'hFFFF;
    for (int m = 0; m < 8; m++) m_l[m] = int'(k[16*m +: 16]);
    a = 0; b = 0; i = 0; j = 0;
    n = 3 * ((m_t > 8) ? m_t : 8);
    for (int c = 0; c < n; c++) begin
      a = rotl((m_s[i] + a + b) & 'hFFFF, 3);
      m_s[i] = a;
      b = rotl((m_l[j] + a + b) & 'hFFFF, (a + b) & 15);
      m_l[j] = b;
      i = (i + 1) % m_t;
      j = (j + 1) % 8;
    end
    m_a = a;
    m_b = b;
  endfunction

  task automatic pulse_start(input logic [127:0] k, input int r);
    @(negedge clk);
    key        = k;
    num_rounds = 5'(r);
    start      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts rising edges after the sampling edge of start until ready is seen.
  task automatic wait_ready(input int c0, input string tag);
    int cnt;
    int exp_lat;
    cnt = c0;
    exp_lat = m_t + 3 * ((m_t > 8) ? m_t : 8) + 1;
    while (!ready && cnt < 400) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    check_eq({tag, " latency"}, cnt, exp_lat);
  endtask

  task automatic check_table(input string tag);
    for (int a = 0; a < m_t; a++) begin
      s_raddr = 6'(a);
      #1;
      check_eq($sformatf("%s S[%0d]", tag, a), {16'd0, s_rdata}, m_s[a]);
    end
  endtask

  task automatic check_regs(input string tag);
`ifdef RC5_KS_ZEROIZE_EN
    for (int m = 0; m < 8; m++) check_eq($sformatf("%s L[%0d]", tag, m), {16'd0, dut.l_q[m]}, 0);
    check_eq({tag, " A"}, {16'd0, dut.a_q}, 0);
    check_eq({tag, " B"}, {16'd0, dut.b_q}, 0);
`else
    for (int m = 0; m < 8; m++) check_eq($sformatf("%s L[%0d]", tag, m), {16'd0, dut.l_q[m]}, m_l[m]);
    check_eq({tag, " A"}, {16'd0, dut.a_q}, m_a);
    check_eq({tag, " B"}, {16'd0, dut.b_q}, m_b);
`endif
  endtask

  task automatic run_and_check(input logic [127:0] k, input int r, input string tag);
    model(k, r);
    pulse_start(k, r);
    check_eq({tag, " busy"}, {31'd0, busy}, 1);
    check_eq({tag, " ready low"}, {31'd0, ready}, 0);
    wait_ready(0, tag);
    check_table(tag);
    check_regs(tag);
  endtask

  initial begin
    logic [127:0] k1, k2, k3, kr;
    int cnt;
    int rr;
    rst        = 1'b1;
    start      = 1'b0;
    key        = '0;
    num_rounds = '0;
    s_raddr    = '0;
    #1;
    check_eq("reset busy", {31'd0, busy}, 0);
    check_eq("reset ready", {31'd0, ready}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_and_check('0, 12, "k0_r12");
    k1 = 128'h0F0E0D0C0B0A09080706050403020100;
    run_and_check(k1, 0, "kseq_r0");
    run_and_check(k1, 31, "kseq_r31");

    // Second start mid-run must be ignored.
    k2 = {$urandom(), $urandom(), $urandom(), $urandom()};
    k3 = {$urandom(), $urandom(), $urandom(), $urandom()};
    model(k2, 12);
    pulse_start(k2, 12);
    cnt = 0;
    while (cnt < 40) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    key        = k3;
    num_rounds = 5'd5;
    start      = 1'b1;
    @(posedge clk);
    cnt++;
    @(negedge clk);
    start = 1'b0;
    wait_ready(cnt, "restart");
    check_table("restart");
    check_regs("restart");

    // Asynchronous reset at MIX cycle 50 of an r=12 run.
    model(k3, 12);
    pulse_start(k3, 12);
    repeat (m_t + 1 + 50) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("abort busy", {31'd0, busy}, 0);
    check_eq("abort ready", {31'd0, ready}, 0);
`ifdef RC5_KS_ZEROIZE_EN
    for (int a = 0; a < 64; a++) begin
      s_raddr = 6'(a);
      #1;
      check_eq($sformatf("zeroize S[%0d]", a), {16'd0, s_rdata}, 0);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    run_and_check(k3, 12, "after_rst");

    for (int n = 0; n < 6; n++) begin
      kr = {$urandom(), $urandom(), $urandom(), $urandom()};
      rr = $urandom_range(0, 31);
      run_and_check(kr, rr, $sformatf("rand%0d_r%0d", n, rr));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
